// File: rtl/fetch_unit.sv
// Instruction-fetch stage: owns the fetch PC, hides the IROM's one-cycle read
// latency and feeds decode from a 2-entry queue with single-cycle redirect.

module fetch_unit_chk (
    input logic       clk,
    input logic       rst_n,
    input logic       push,
    input logic       valid,
    input logic [1:0] count
);

    // Credit accounting must keep the queue from ever overflowing.
    a_no_overflow: assert property (@(posedge clk) disable iff (!rst_n)
        !(push && (count == 2'd2)));

    a_count_range: assert property (@(posedge clk) disable iff (!rst_n)
        count != 2'd3);

    a_valid_tracks_count: assert property (@(posedge clk) disable iff (!rst_n)
        valid == (count != 2'd0));

endmodule

module fetch_unit #(
    parameter int                    ARCH_WIDTH = 32,
    parameter int                    IM_WIDTH   = 32,
    parameter logic [ARCH_WIDTH-1:0] RESET_PC   = {ARCH_WIDTH{1'b0}}
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  redirect_valid,
    input  logic [ARCH_WIDTH-1:0] redirect_pc,
    output logic [ARCH_WIDTH-1:0] im_addr,
    input  logic [0:IM_WIDTH-1]   im_dout,
    output logic                  if_valid,
    input  logic                  if_ready,
    output logic [ARCH_WIDTH-1:0] if_pc,
    output logic [0:IM_WIDTH-1]   if_instr
);

    localparam logic [ARCH_WIDTH-1:0] PC_STEP    = {{(ARCH_WIDTH-3){1'b0}}, 3'd4};
    localparam logic [ARCH_WIDTH-1:0] ALIGN_MASK = {{(ARCH_WIDTH-2){1'b1}}, 2'b00};
    localparam logic [ARCH_WIDTH-1:0] PC_ZERO    = {ARCH_WIDTH{1'b0}};
    localparam logic [0:IM_WIDTH-1]   INSTR_ZERO = {IM_WIDTH{1'b0}};

    logic [ARCH_WIDTH-1:0] pc_r;
    logic                  infl_r;
    logic [ARCH_WIDTH-1:0] infl_pc_r;

    logic [1:0]            count_r;
    logic                  valid_r;
    logic [ARCH_WIDTH-1:0] hd_pc_r;
    logic [0:IM_WIDTH-1]   hd_instr_r;
    logic [ARCH_WIDTH-1:0] tl_pc_r;
    logic [0:IM_WIDTH-1]   tl_instr_r;

    logic                  pop_s;
    logic                  push_s;
    logic                  issue_s;
    logic [2:0]            occ_s;
    logic [ARCH_WIDTH-1:0] addr_s;

    // Issue address selection and credit check; occupancy counts the queue
    // plus the outstanding IM read, net of the entry decode takes this cycle.
    always_comb begin
        pop_s   = 1'b0;
        push_s  = 1'b0;
        addr_s  = pc_r;
        occ_s   = 3'd0;
        issue_s = 1'b0;

        pop_s  = valid_r & if_ready;
        push_s = infl_r & ~redirect_valid;

        if (redirect_valid) begin
            addr_s = redirect_pc & ALIGN_MASK;
        end else begin
            addr_s = pc_r;
        end

        occ_s   = {1'b0, count_r} + {2'b00, infl_r} - {2'b00, pop_s};
        issue_s = redirect_valid | (occ_s < 3'd2);
    end

    assign im_addr  = addr_s;
    assign if_valid = valid_r;
    assign if_pc    = hd_pc_r;
    assign if_instr = hd_instr_r;

    // Fetch PC and in-flight read tracking.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            pc_r      <= RESET_PC;
            infl_r    <= 1'b0;
            infl_pc_r <= PC_ZERO;
        end else if (issue_s) begin
            pc_r      <= addr_s + PC_STEP;
            infl_r    <= 1'b1;
            infl_pc_r <= addr_s;
        end else begin
            infl_r    <= 1'b0;
        end
    end

    // Two-entry shift queue; the head registers drive decode directly and are
    // zeroed whenever the queue empties so an idle head reads as 0.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            count_r    <= 2'd0;
            valid_r    <= 1'b0;
            hd_pc_r    <= PC_ZERO;
            hd_instr_r <= INSTR_ZERO;
            tl_pc_r    <= PC_ZERO;
            tl_instr_r <= INSTR_ZERO;
        end else if (redirect_valid) begin
            count_r    <= 2'd0;
            valid_r    <= 1'b0;
            hd_pc_r    <= PC_ZERO;
            hd_instr_r <= INSTR_ZERO;
        end else begin
            case ({push_s, pop_s})
                2'b10: begin
                    if (count_r == 2'd0) begin
                        hd_pc_r    <= infl_pc_r;
                        hd_instr_r <= im_dout;
                        valid_r    <= 1'b1;
                        count_r    <= 2'd1;
                    end else begin
                        tl_pc_r    <= infl_pc_r;
                        tl_instr_r <= im_dout;
                        count_r    <= 2'd2;
                    end
                end
                2'b01: begin
                    if (count_r == 2'd2) begin
                        hd_pc_r    <= tl_pc_r;
                        hd_instr_r <= tl_instr_r;
                        count_r    <= 2'd1;
                    end else begin
                        hd_pc_r    <= PC_ZERO;
                        hd_instr_r <= INSTR_ZERO;
                        valid_r    <= 1'b0;
                        count_r    <= 2'd0;
                    end
                end
                2'b11: begin
                    if (count_r == 2'd2) begin
                        hd_pc_r    <= tl_pc_r;
                        hd_instr_r <= tl_instr_r;
                        tl_pc_r    <= infl_pc_r;
                        tl_instr_r <= im_dout;
                    end else begin
                        hd_pc_r    <= infl_pc_r;
                        hd_instr_r <= im_dout;
                    end
                end
                default: begin
                    count_r <= count_r;
                end
            endcase
        end
    end

    fetch_unit_chk u_chk (
        .clk   (clk),
        .rst_n (rst_n),
        .push  (push_s),
        .valid (valid_r),
        .count (count_r)
    );

endmodule

// File: tb/tb_fetch_unit.sv
// Scoreboard bench for fetch_unit: directed stimulus pushes expected {pc,instr}
// pairs, negedge monitors pop and compare every accepted instruction.

module tb_fetch_unit;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        redirect_valid;
    logic [31:0] redirect_pc;
    logic [31:0] im_addr;
    logic [0:31] im_dout;
    logic        if_valid;
    logic        if_ready;
    logic [31:0] if_pc;
    logic [0:31] if_instr;

    logic        rst2_n;
    logic [31:0] im_addr2;
    logic [0:31] im_dout2;
    logic        if_valid2;
    logic [31:0] if_pc2;
    logic [0:31] if_instr2;

    logic [63:0] q[$];
    logic [63:0] q2[$];
    int n_cmp = 0;
    int n_err = 0;

    fetch_unit #(.RESET_PC(32'h0000_0000)) dut (
        .clk(clk), .rst_n(rst_n), .redirect_valid(redirect_valid),
        .redirect_pc(redirect_pc), .im_addr(im_addr), .im_dout(im_dout),
        .if_valid(if_valid), .if_ready(if_ready), .if_pc(if_pc), .if_instr(if_instr)
    );

    fetch_unit #(.RESET_PC(32'hFFFF_FFF8)) dut2 (
        .clk(clk), .rst_n(rst2_n), .redirect_valid(1'b0),
        .redirect_pc(32'h0000_0000), .im_addr(im_addr2), .im_dout(im_dout2),
        .if_valid(if_valid2), .if_ready(1'b1), .if_pc(if_pc2), .if_instr(if_instr2)
    );

    always #5 clk = ~clk;

    // IM word k holds 32'h1000_0000 + k, indexed by addr[11:2].
    function automatic logic [31:0] rom_word(input logic [9:0] idx);
        return 32'h1000_0000 + {22'd0, idx};
    endfunction

    always @(posedge clk) begin
        im_dout  <= rom_word(im_addr[11:2]);
        im_dout2 <= rom_word(im_addr2[11:2]);
    end

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %h, expected %h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic push_seq(input logic [31:0] start, input int n);
        for (int i = 0; i < n; i++) begin
            logic [31:0] p;
            p = start + 32'(4 * i);
            q.push_back({p, rom_word(p[11:2])});
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Monitor for the main instance: every accepted head must match the queue.
    always @(negedge clk) begin
        if (rst_n && if_valid && if_ready && !redirect_valid) begin
            if (q.size() == 0) begin
                n_cmp++;
                n_err++;
                $display("FAIL unexpected_deliver: got pc %h, expected none", if_pc);
            end else begin
                logic [63:0] e;
                e = q.pop_front();
                chk("deliver_pc", if_pc, e[63:32]);
                chk("deliver_instr", if_instr, e[31:0]);
            end
        end
    end

    // Monitor for the wrap-around instance (decode always ready).
    always @(negedge clk) begin
        if (rst2_n && if_valid2) begin
            if (q2.size() == 0) begin
                n_cmp++;
                n_err++;
                $display("FAIL unexpected_deliver2: got pc %h, expected none", if_pc2);
            end else begin
                logic [63:0] e;
                e = q2.pop_front();
                chk("wrap_pc", if_pc2, e[63:32]);
                chk("wrap_instr", if_instr2, e[31:0]);
            end
        end
    end

    initial begin
        rst_n          = 1'b0;
        rst2_n         = 1'b0;
        redirect_valid = 1'b0;
        redirect_pc    = 32'h0000_0000;
        if_ready       = 1'b1;
        repeat (3) tick();

        chk("rst_valid", {31'd0, if_valid}, 32'd0);
        chk("rst_pc", if_pc, 32'h0000_0000);
        chk("rst_instr", if_instr, 32'h0000_0000);
        chk("rst_addr", im_addr, 32'h0000_0000);
        chk("rst_addr2", im_addr2, 32'hFFFF_FFF8);

        // Reset release and sequential stream.
        push_seq(32'h0000_0000, 40);
        rst_n = 1'b1;
        for (int c = 0; c < 8; c++) begin
            chk("seq_addr", im_addr, 32'(4 * c));
            if (c == 1) chk("first_valid_low", {31'd0, if_valid}, 32'd0);
            if (c == 2) begin
                chk("first_valid_high", {31'd0, if_valid}, 32'd1);
                chk("first_pc", if_pc, 32'h0000_0000);
                chk("first_instr", if_instr, 32'h1000_0000);
            end
            tick();
        end

        // Stall: queue fills, issue stops, head stays stable.
        if_ready = 1'b0;
        for (int c = 8; c < 13; c++) begin
            #1;
            chk("stall_addr", im_addr, 32'h0000_0020);
            chk("stall_pc", if_pc, 32'h0000_0018);
            chk("stall_instr", if_instr, 32'h1000_0006);
            tick();
        end
        if_ready = 1'b1;
        #1;
        chk("resume_addr", im_addr, 32'h0000_0020);
        for (int c = 13; c < 18; c++) tick();

        // Fill the queue, then redirect to an unaligned target.
        if_ready = 1'b0;
        tick();
        chk("fill_valid", {31'd0, if_valid}, 32'd1);
        if_ready       = 1'b1;
        redirect_valid = 1'b1;
        redirect_pc    = 32'h0000_0203;
        q.delete();
        push_seq(32'h0000_0200, 20);
        #1;
        chk("redir_addr", im_addr, 32'h0000_0200);
        tick();
        redirect_valid = 1'b0;
        #1;
        chk("redir_flush", {31'd0, if_valid}, 32'd0);
        chk("redir_next_addr", im_addr, 32'h0000_0204);
        tick();
        chk("redir_valid", {31'd0, if_valid}, 32'd1);
        chk("redir_pc", if_pc, 32'h0000_0200);
        chk("redir_instr", if_instr, 32'h1000_0080);
        repeat (4) tick();

        // Back-to-back redirects: only the second target survives.
        redirect_valid = 1'b1;
        redirect_pc    = 32'h0000_0040;
        q.delete();
        #1;
        chk("b2b_addr0", im_addr, 32'h0000_0040);
        tick();
        redirect_pc = 32'h0000_0080;
        q.delete();
        push_seq(32'h0000_0080, 20);
        #1;
        chk("b2b_addr1", im_addr, 32'h0000_0080);
        tick();
        redirect_valid = 1'b0;
        #1;
        chk("b2b_flush", {31'd0, if_valid}, 32'd0);
        tick();
        chk("b2b_pc", if_pc, 32'h0000_0080);
        repeat (3) tick();

        // Asynchronous reset with two entries queued.
        if_ready = 1'b0;
        repeat (2) tick();
        chk("pre_rst_valid", {31'd0, if_valid}, 32'd1);
        #2;
        rst_n = 1'b0;
        q.delete();
        push_seq(32'h0000_0000, 20);
        #1;
        chk("mid_rst_valid", {31'd0, if_valid}, 32'd0);
        chk("mid_rst_pc", if_pc, 32'h0000_0000);
        chk("mid_rst_addr", im_addr, 32'h0000_0000);
        repeat (2) tick();
        rst_n    = 1'b1;
        if_ready = 1'b1;
        repeat (2) tick();
        chk("restart_valid", {31'd0, if_valid}, 32'd1);
        chk("restart_pc", if_pc, 32'h0000_0000);
        repeat (3) tick();

        // PC wrap from 32'hFFFF_FFF8 on the second instance.
        q2.push_back({32'hFFFF_FFF8, 32'h1000_03FE});
        q2.push_back({32'hFFFF_FFFC, 32'h1000_03FF});
        q2.push_back({32'h0000_0000, 32'h1000_0000});
        q2.push_back({32'h0000_0004, 32'h1000_0001});
        rst2_n = 1'b1;
        #1;
        chk("wrap_addr0", im_addr2, 32'hFFFF_FFF8);
        tick();
        chk("wrap_addr1", im_addr2, 32'hFFFF_FFFC);
        tick();
        chk("wrap_addr2", im_addr2, 32'h0000_0000);
        chk("wrap_head", if_pc2, 32'hFFFF_FFF8);
        repeat (4) tick();
        rst2_n = 1'b0;
        chk("wrap_drained", 32'(q2.size()), 32'd0);
        repeat (2) tick();

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
